// File: rtl/alu_writeback_pkg.sv
// Shared types, op codes and address constants for the ALU writeback stage.
// The flag-mask decode is kept here so the producer and this stage agree on it.
package alu_writeback_pkg;

    localparam int ALU_CS_LEN = 3;

    localparam logic [ALU_CS_LEN:0] ALU_CS_NOP      = 4'd0;
    localparam logic [ALU_CS_LEN:0] ALU_CS_ADD      = 4'd1;
    localparam logic [ALU_CS_LEN:0] ALU_CS_ADDC     = 4'd2;
    localparam logic [ALU_CS_LEN:0] ALU_CS_SUB      = 4'd3;
    localparam logic [ALU_CS_LEN:0] ALU_CS_AND      = 4'd4;
    localparam logic [ALU_CS_LEN:0] ALU_CS_XOR      = 4'd5;
    localparam logic [ALU_CS_LEN:0] ALU_CS_OR       = 4'd6;
    localparam logic [ALU_CS_LEN:0] ALU_CS_SHIFT_OP = 4'd7;

    localparam logic [7:0] ACC_ADDR_DEF = 8'hE0;
    localparam logic [7:0] PSW_ADDR_DEF = 8'hD0;

    localparam int PSW_CY  = 7;
    localparam int PSW_AC  = 6;
    localparam int PSW_F0  = 5;
    localparam int PSW_RS1 = 4;
    localparam int PSW_RS0 = 3;
    localparam int PSW_OV  = 2;
    localparam int PSW_F1  = 1;
    localparam int PSW_P   = 0;

    // One buffered result; mask bit order is {CY, AC, OV}
    typedef struct packed {
        logic [2:0] mask;
        logic       c;
        logic       ac;
        logic       ov;
        logic [7:0] dest;
        logic [7:0] data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    function automatic logic [2:0] flag_mask(input logic [ALU_CS_LEN:0] op);
        logic [2:0] m;
        case (op)
            ALU_CS_ADD, ALU_CS_ADDC, ALU_CS_SUB: m = 3'b111;
            ALU_CS_AND, ALU_CS_XOR, ALU_CS_OR,
            ALU_CS_SHIFT_OP, ALU_CS_NOP:         m = 3'b000;
            default:                             m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Two-entry skid FIFO with toggling 1-bit pointers and a 0..2 occupancy count.
// Push while full and pop while empty are ignored.
module alu_wb_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == DEPTH_CNT);
    assign empty     = (count_r == 2'd0);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign head      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; cleared entries make head read as zero after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// Buffers ALU results, writes them to the RAM/SFR bus and keeps in-order
// ACC and PSW shadows; P is always the even parity of the ACC shadow.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int         DEPTH    = 2,
    parameter logic [7:0] ACC_ADDR = 8'hE0,
    parameter logic [7:0] PSW_ADDR = 8'hD0,
    parameter logic [7:0] PSW_RST  = 8'h00
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ALU_CS_LEN:0]   i_operation,
    input  logic [7:0]            i_des1,
    input  logic                  i_desC,
    input  logic                  i_desAc,
    input  logic                  i_desOv,
    input  logic [7:0]            i_dest,
    output logic                  o_wr_en,
    input  logic                  i_wr_ready,
    output logic [7:0]            o_wr_addr,
    output logic [7:0]            o_wr_data,
    input  logic                  i_sfr_wr_en,
    input  logic [7:0]            i_sfr_wr_addr,
    input  logic [7:0]            i_sfr_wr_data,
    output logic [7:0]            o_psw,
    output logic [7:0]            o_acc
);

    wb_entry_t   in_entry_s;
    wb_entry_t   head_s;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic        ready_r;
    logic [7:0]  acc_r;
    logic [7:1]  psw_r;
    logic [7:0]  acc_n_s;
    logic [7:1]  psw_n_s;

    // Flag mask is decoded once at capture and travels with the entry
    always_comb begin
        in_entry_s      = '0;
        in_entry_s.mask = flag_mask(i_operation);
        in_entry_s.c    = i_desC;
        in_entry_s.ac   = i_desAc;
        in_entry_s.ov   = i_desOv;
        in_entry_s.dest = i_dest;
        in_entry_s.data = i_des1;
    end

    assign push_s = i_valid & o_ready;
    assign pop_s  = o_wr_en & i_wr_ready;

    alu_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push_s),
        .wdata (in_entry_s),
        .pop   (pop_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    // Holds o_ready low through reset and until the first edge after release
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    assign o_ready   = ready_r & ~full_s;
    assign o_wr_en   = ~empty_s;
    assign o_wr_addr = head_s.dest;
    assign o_wr_data = head_s.data;

    // Snoop applied first, then the pop overrides only the bits it owns
    always_comb begin
        acc_n_s = acc_r;
        psw_n_s = psw_r;
        if (i_sfr_wr_en && (i_sfr_wr_addr == ACC_ADDR)) begin
            acc_n_s = i_sfr_wr_data;
        end else if (i_sfr_wr_en && (i_sfr_wr_addr == PSW_ADDR)) begin
            psw_n_s = i_sfr_wr_data[7:1];
        end else begin
            acc_n_s = acc_r;
        end
        if (pop_s) begin
            if (head_s.dest == ACC_ADDR) begin
                acc_n_s = head_s.data;
            end else begin
                acc_n_s = acc_n_s;
            end
            if (head_s.dest == PSW_ADDR) begin
                psw_n_s = head_s.data[7:1];
            end else begin
                if (head_s.mask[2]) psw_n_s[PSW_CY] = head_s.c;
                else                psw_n_s[PSW_CY] = psw_n_s[PSW_CY];
                if (head_s.mask[1]) psw_n_s[PSW_AC] = head_s.ac;
                else                psw_n_s[PSW_AC] = psw_n_s[PSW_AC];
                if (head_s.mask[0]) psw_n_s[PSW_OV] = head_s.ov;
                else                psw_n_s[PSW_OV] = psw_n_s[PSW_OV];
            end
        end else begin
            psw_n_s = psw_n_s;
        end
    end

    // Shadow registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_r <= 8'h00;
            psw_r <= PSW_RST[7:1];
        end else begin
            acc_r <= acc_n_s;
            psw_r <= psw_n_s;
        end
    end

    assign o_acc = acc_r;
    assign o_psw = {psw_r, ^acc_r};

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: hand-computed vectors, sampled on the falling edge.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                valid = 1'b0;
    logic                ready;
    logic [ALU_CS_LEN:0] op = 4'd0;
    logic [7:0]          des1 = 8'h00;
    logic                des_c = 1'b0, des_ac = 1'b0, des_ov = 1'b0;
    logic [7:0]          dest = 8'h00;
    logic                wr_en;
    logic                wr_ready = 1'b0;
    logic [7:0]          wr_addr, wr_data;
    logic                sfr_en = 1'b0;
    logic [7:0]          sfr_addr = 8'h00, sfr_data = 8'h00;
    logic [7:0]          psw, acc;

    int total = 0;
    int passed = 0;
    int failed = 0;

    alu_writeback dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_operation   (op),
        .i_des1        (des1),
        .i_desC        (des_c),
        .i_desAc       (des_ac),
        .i_desOv       (des_ov),
        .i_dest        (dest),
        .o_wr_en       (wr_en),
        .i_wr_ready    (wr_ready),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .i_sfr_wr_en   (sfr_en),
        .i_sfr_wr_addr (sfr_addr),
        .i_sfr_wr_data (sfr_data),
        .o_psw         (psw),
        .o_acc         (acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_entry(input logic [3:0] o, input logic [7:0] d, input logic c,
                             input logic a, input logic v, input logic [7:0] ds);
        valid = 1'b1; op = o; des1 = d; des_c = c; des_ac = a; des_ov = v; dest = ds;
    endtask

    // Drive one entry for a single edge (caller guarantees o_ready is high)
    task automatic push_one(input logic [3:0] o, input logic [7:0] d, input logic c,
                            input logic a, input logic v, input logic [7:0] ds);
        set_entry(o, d, c, a, v, ds);
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_ready", {7'd0, ready}, 8'h00);
        check("rst_wr_en", {7'd0, wr_en}, 8'h00);
        check("rst_addr", wr_addr, 8'h00);
        check("rst_data", wr_data, 8'h00);
        check("rst_psw", psw, 8'h00);
        check("rst_acc", acc, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {7'd0, ready}, 8'h01);

        // 1: ADD 80 to ACC, flags C=0 AC=1 OV=1
        wr_ready = 1'b1;
        push_one(ALU_CS_ADD, 8'h80, 1'b0, 1'b1, 1'b1, 8'hE0);
        check("t1_wr_en", {7'd0, wr_en}, 8'h01);
        check("t1_addr", wr_addr, 8'hE0);
        check("t1_data", wr_data, 8'h80);
        check("t1_acc_before", acc, 8'h00);
        @(negedge clk);
        check("t1_wr_en_drop", {7'd0, wr_en}, 8'h00);
        check("t1_acc", acc, 8'h80);
        check("t1_psw", psw, 8'h45);

        // 3: set CY via ADD to RAM, then AND 03 to ACC keeps CY
        push_one(ALU_CS_ADD, 8'h55, 1'b1, 1'b0, 1'b0, 8'h30);
        @(negedge clk);
        check("t3_psw_cy", psw, 8'h81);
        push_one(ALU_CS_AND, 8'h03, 1'b0, 1'b1, 1'b1, 8'hE0);
        @(negedge clk);
        check("t3_acc", acc, 8'h03);
        check("t3_psw", psw, 8'h80);

        // 2: backpressure with three results, then in-order drain
        wr_ready = 1'b0;
        set_entry(ALU_CS_NOP, 8'h11, 1'b1, 1'b1, 1'b1, 8'h30);
        @(negedge clk);
        check("t2_ready_1", {7'd0, ready}, 8'h01);
        set_entry(ALU_CS_NOP, 8'h22, 1'b1, 1'b1, 1'b1, 8'h31);
        @(negedge clk);
        check("t2_ready_2", {7'd0, ready}, 8'h00);
        check("t2_head_addr", wr_addr, 8'h30);
        check("t2_head_data", wr_data, 8'h11);
        set_entry(ALU_CS_NOP, 8'h33, 1'b1, 1'b1, 1'b1, 8'h32);
        @(negedge clk);
        check("t2_ready_held", {7'd0, ready}, 8'h00);
        check("t2_head_stable", wr_data, 8'h11);
        wr_ready = 1'b1;
        @(negedge clk);
        check("t2_drain_b_addr", wr_addr, 8'h31);
        check("t2_drain_b_data", wr_data, 8'h22);
        check("t2_ready_back", {7'd0, ready}, 8'h01);
        @(negedge clk);
        valid = 1'b0;
        check("t2_drain_c_addr", wr_addr, 8'h32);
        check("t2_drain_c_data", wr_data, 8'h33);
        @(negedge clk);
        check("t2_empty", {7'd0, wr_en}, 8'h00);
        check("t2_psw", psw, 8'h80);

        // 4: ADD direct to PSW, ALU flags ignored
        push_one(ALU_CS_ADD, 8'h18, 1'b1, 1'b1, 1'b1, 8'hD0);
        @(negedge clk);
        check("t4_psw", psw, 8'h18);

        // 5: pop to ACC wins over same-cycle ACC snoop
        push_one(ALU_CS_AND, 8'h01, 1'b0, 1'b0, 1'b0, 8'hE0);
        sfr_en = 1'b1; sfr_addr = 8'hE0; sfr_data = 8'h07;
        @(negedge clk);
        sfr_en = 1'b0;
        check("t5_acc", acc, 8'h01);
        check("t5_psw", psw, 8'h19);

        // Snoop-only writes: PSW bit 0 ignored, ACC snoop drives P
        sfr_en = 1'b1; sfr_addr = 8'hD0; sfr_data = 8'hA4;
        @(negedge clk);
        check("snoop_psw", psw, 8'hA5);
        sfr_addr = 8'hE0; sfr_data = 8'h0F;
        @(negedge clk);
        sfr_en = 1'b0;
        check("snoop_acc", acc, 8'h0F);
        check("snoop_acc_psw", psw, 8'hA4);

        // Flag-only pop combines bitwise with a PSW snoop
        push_one(ALU_CS_SUB, 8'h99, 1'b0, 1'b1, 1'b0, 8'h30);
        sfr_en = 1'b1; sfr_addr = 8'hD0; sfr_data = 8'h3B;
        @(negedge clk);
        sfr_en = 1'b0;
        check("combine_psw", psw, 8'h7A);

        // Unknown op code updates no flags
        push_one(4'hC, 8'h00, 1'b1, 1'b0, 1'b1, 8'h30);
        @(negedge clk);
        check("unknown_op_psw", psw, 8'h7A);

        // 6: reset with two entries pending
        wr_ready = 1'b0;
        set_entry(ALU_CS_ADD, 8'hAA, 1'b1, 1'b1, 1'b1, 8'hE0);
        @(negedge clk);
        set_entry(ALU_CS_ADD, 8'hBB, 1'b1, 1'b1, 1'b1, 8'hD0);
        @(negedge clk);
        valid = 1'b0;
        check("t6_pending", {7'd0, wr_en}, 8'h01);
        #2 rst = 1'b1;
        #1;
        check("t6_wr_en_now", {7'd0, wr_en}, 8'h00);
        check("t6_ready_in_rst", {7'd0, ready}, 8'h00);
        check("t6_psw_in_rst", psw, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_write", {7'd0, wr_en}, 8'h00);
        end
        check("t6_psw", psw, 8'h00);
        check("t6_acc", acc, 8'h00);
        check("t6_ready", {7'd0, ready}, 8'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream neighbour of the 8051 ALU.
- Captures each ALU result (o_des1 and the C/AC/OV flags) together with its destination direct address, and buffers it in a 2-entry skid FIFO.
- Issues the data write to the internal RAM/SFR bus with a valid/ready handshake.
- Commits CY/AC/OV to a local PSW shadow in program order, and maintains P from an ACC shadow.

Parameters:
- DEPTH, 2, FIFO entries; 2 only, no other value supported.
- ACC_ADDR, 8'hE0, direct address of ACC.
- PSW_ADDR, 8'hD0, direct address of PSW.
- PSW_RST, 8'h00, PSW shadow reset value.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  ALU result valid.
- o_ready  out  1  stage can accept an entry.
- i_operation  in  `ALU_CS_LEN+1  op code travelling with the result.
- i_des1  in  8  ALU result.
- i_desC  in  1  ALU carry flag.
- i_desAc  in  1  ALU auxiliary-carry flag.
- i_desOv  in  1  ALU overflow flag.
- i_dest  in  8  destination direct address.
- o_wr_en  out  1  bus write request.
- i_wr_ready  in  1  bus accepts the write this cycle.
- o_wr_addr  out  8  bus write address.
- o_wr_data  out  8  bus write data.
- i_sfr_wr_en  in  1  snoop: other write to the SFR space.
- i_sfr_wr_addr  in  8  snoop address.
- i_sfr_wr_data  in  8  snoop data.
- o_psw  out  8  PSW shadow to the controller and ALU (CY feeds i_srcC).
- o_acc  out  8  ACC shadow.

Behaviour:
- Reset (async, i_rst=1):
  - FIFO emptied; o_ready=0 while reset is asserted, 1 on the first edge after release.
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_acc=0, o_psw=PSW_RST.
  - Reset mid-operation discards all buffered entries; no partial write is issued.
- Accept: push occurs when i_valid && o_ready. o_ready = (count<2), derived from registered state.
- Write handshake:
  - o_wr_en=1 whenever the FIFO is non-empty; head fields drive o_wr_addr/o_wr_data.
  - Pop occurs when o_wr_en && i_wr_ready.
  - Latency: push at edge N makes o_wr_en=1 after edge N; earliest pop at edge N+1.
  - Entry held stable while i_wr_ready=0.
- Simultaneous push and pop at count=2 is not possible, since o_ready=0. At count=1 or 0 it is allowed and count is unchanged.
- Flag mask, derived from i_operation at push and stored per entry:
  - ADD, ADDC, SUB update CY, AC, OV.
  - AND, XOR, OR, SHIFT_OP, NOP update none.
  - Unknown codes update none.
- Commit at pop, in order:
  - If head dest==ACC_ADDR: o_acc <= data.
  - If head dest==PSW_ADDR: o_psw[7:1] <= data[7:1], and the flag mask is ignored (the direct write wins).
  - Otherwise, masked bits are written: o_psw[7]=C, o_psw[6]=AC, o_psw[2]=OV.
- Parity: o_psw[0] = ^o_acc at all times, combinational from the ACC shadow, even parity as on the 8051. The registered value of bit 0 is never written.
- Snoop:
  - i_sfr_wr_en to ACC_ADDR or PSW_ADDR updates the corresponding shadow; the PSW bit-0 write is ignored.
  - If a pop commits to the same shadow in the same cycle, the pop wins. Flag-only commits and snoop PSW writes combine bitwise: the pop owns its masked bits, the snoop owns the rest.
- Wrap-around: read and write pointers are 1-bit and toggle; count is 0..2.

Decomposition:
- Defines.v:
  - Existing ALU_CS_* codes.
  - Add ACC/PSW address defines.
  - Add PSW bit indices: CY=7, AC=6, F0=5, RS1=4, RS0=3, OV=2, F1=1, P=0.
- Sub-module alu_wb_fifo:
  - Generic 2-entry FIFO carrying {mask[2:0], C, AC, OV, dest[7:0], data[7:0]}.
  - Exposes push, pop, full, empty and head.
- Flag/commit logic stays in alu_writeback.

Test Plan:
1. ADD result des1=8'h80, C=0, AC=1, OV=1, dest=ACC, i_wr_ready=1 -> o_wr_en pulses for one cycle with addr E0, data 80; then o_acc=80, o_psw=8'h45.
2. i_wr_ready=0, three back-to-back valid results -> o_ready drops after the 2nd push; the 3rd is held by the producer. Raising i_wr_ready drains entries in push order on consecutive cycles.
3. Prior o_psw CY=1, then AND result 8'h03 to ACC -> o_psw=8'h80 (CY kept, P=0 since 03 has even parity).
4. ADD result to dest=PSW_ADDR, data 8'h18 -> o_psw=8'h18 | parity(acc); flags C/AC/OV from the ALU are ignored.
5. Snoop ACC<=8'h07 in the same cycle as a pop committing ACC<=8'h01 -> o_acc=01, P=1.
6. i_rst asserted while two entries are pending with i_wr_ready=0 -> o_wr_en=0 immediately; after release no write is ever issued and o_psw=00.
